// File: rtl/reg_file_pkg.sv
// Shared defaults and storage types for the reg_file_sb register file slice.
package reg_file_pkg;
  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DEF_D  = 3;
  localparam int unsigned DEF_NR = 2;

  typedef logic [DEF_D-1:0] reg_addr_t;
  typedef logic [DEF_W-1:0] reg_data_t;

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: issue sets, writeback clears, registered popcount, per-port Busy.
// Honours ZERO_REG_EN (register 0 never becomes pending).
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned D  = DEF_D,
  parameter int unsigned NR = DEF_NR
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          IssueEn,
  input  logic [D-1:0]  IssueAddr,
  input  logic          WriteEn,
  input  logic [D-1:0]  Waddr,
  input  logic [NR*D-1:0] Raddr,
  output logic [NR-1:0] Busy,
  output logic [D:0]    PendCount
);
  localparam int unsigned DEPTH = 2**D;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [D:0]       count_nxt;
  logic             wr_ok;
  logic             iss_ok;

  assign wr_ok  = WriteEn && !(ZERO_REG && (Waddr == '0));
  assign iss_ok = IssueEn && !(ZERO_REG && (IssueAddr == '0));

  // Issue is applied after the clear so a same-address collision leaves the entry pending.
  always_comb begin
    pending_nxt = pending;
    if (wr_ok)
      pending_nxt[Waddr] = 1'b0;
    if (iss_ok)
      pending_nxt[IssueAddr] = 1'b1;
  end

  always_comb begin
    count_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      count_nxt = count_nxt + {{D{1'b0}}, pending_nxt[i]};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending   <= '0;
      PendCount <= '0;
    end else begin
      pending   <= pending_nxt;
      PendCount <= count_nxt;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_busy
    logic [D-1:0] addr;
    assign addr    = Raddr[p*D +: D];
    assign Busy[p] = pending[addr] && !(WriteEn && (Waddr == addr))
                     && !(ZERO_REG && (addr == '0));
  end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-to-read bypass and pending-write scoreboard.
// Optional build macro ZERO_REG_EN hardwires register 0 to zero.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned D  = DEF_D,
  parameter int unsigned NR = DEF_NR
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            WriteEn,
  input  logic [D-1:0]    Waddr,
  input  logic [W-1:0]    DataIn,
  input  logic            IssueEn,
  input  logic [D-1:0]    IssueAddr,
  input  logic [NR*D-1:0] Raddr,
  output logic [NR*W-1:0] DataOut,
  output logic [NR-1:0]   Busy,
  output logic [D:0]      PendCount
);
  localparam int unsigned DEPTH = 2**D;

  logic [W-1:0] regs [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (WriteEn && !(ZERO_REG && (Waddr == '0))) begin
      regs[Waddr] <= DataIn;
    end
  end

  // Hardwired zero takes priority over the bypass path.
  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [D-1:0] addr;
    assign addr = Raddr[p*D +: D];
    always_comb begin
      if (ZERO_REG && (addr == '0))
        DataOut[p*W +: W] = '0;
      else if (WriteEn && (Waddr == addr))
        DataOut[p*W +: W] = DataIn;
      else
        DataOut[p*W +: W] = regs[addr];
    end
  end

  reg_scoreboard #(
    .D  (D),
    .NR (NR)
  ) u_sb (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .WriteEn   (WriteEn),
    .Waddr     (Waddr),
    .Raddr     (Raddr),
    .Busy      (Busy),
    .PendCount (PendCount)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed + random bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
  localparam int unsigned W = 8, D = 3, NR = 2, DEPTH = 8;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            WriteEn, IssueEn;
  logic [D-1:0]    Waddr, IssueAddr;
  logic [W-1:0]    DataIn;
  logic [NR*D-1:0] Raddr;
  logic [NR*W-1:0] DataOut;
  logic [NR-1:0]   Busy;
  logic [D:0]      PendCount;

  int vectors = 0;
  int miscompares = 0;
  int unsigned m_reg [DEPTH];
  bit          m_pend[DEPTH];

  always #5 Clk = ~Clk;

  reg_file_sb #(.W(W), .D(D), .NR(NR)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .Raddr(Raddr), .DataOut(DataOut),
    .Busy(Busy), .PendCount(PendCount)
  );

  function automatic bit hw0(int unsigned a);
    return ZR && (a == 0);
  endfunction

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = 0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int unsigned model_count();
    int unsigned c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_pend[i];
    return c;
  endfunction

  task automatic check_outputs(string tag);
    for (int p = 0; p < NR; p++) begin
      int unsigned a, ed;
      bit hit, eb;
      a   = Raddr[p*D +: D];
      hit = WriteEn && (Waddr == a);
      ed  = hw0(a) ? 0 : (hit ? DataIn : m_reg[a]);
      eb  = !hw0(a) && m_pend[a] && !hit;
      chk($sformatf("%s_data%0d", tag, p), DataOut[p*W +: W], ed);
      chk($sformatf("%s_busy%0d", tag, p), Busy[p], eb);
    end
    chk({tag, "_pendcount"}, PendCount, model_count());
  endtask

  // Advance one rising edge, committing the current inputs into the model.
  task automatic clock();
    @(posedge Clk);
    if (Reset_n) begin
      if (WriteEn && !hw0(Waddr)) begin
        m_reg[Waddr]  = DataIn;
        m_pend[Waddr] = 1'b0;
      end
      if (IssueEn && !hw0(IssueAddr)) m_pend[IssueAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    WriteEn = 1'b0; IssueEn = 1'b0;
  endtask

  task automatic rd(int unsigned a0, int unsigned a1);
    Raddr[0*D +: D] = D'(a0);
    Raddr[1*D +: D] = D'(a1);
  endtask

  task automatic wr(int unsigned a, int unsigned d);
    WriteEn = 1'b1; Waddr = D'(a); DataIn = W'(d);
  endtask

  task automatic iss(int unsigned a);
    IssueEn = 1'b1; IssueAddr = D'(a);
  endtask

  initial begin
    model_clear();
    Reset_n = 1'b0; idle(); Waddr = '0; DataIn = '0; IssueAddr = '0; rd(0, 0);
    #3;
    check_outputs("reset");
    @(negedge Clk); Reset_n = 1'b1;
    clock();

    // reset discards stored data immediately
    wr(3, 'hAA); clock(); idle(); rd(3, 3);
    #1; check_outputs("t1_pre");
    chk("t1_pre_r3", DataOut[W-1:0], 'hAA);
    #2; Reset_n = 1'b0; model_clear();
    #1; check_outputs("t1_rst");
    chk("t1_rst_r3", DataOut[W-1:0], 0);
    Reset_n = 1'b1;
    clock();

    // same-cycle bypass, then stored value
    wr(5, 'h3C); rd(5, 1);
    #1; check_outputs("t2_byp");
    chk("t2_byp_d0", DataOut[W-1:0], 'h3C);
    clock(); idle();
    #1; check_outputs("t2_hold");
    chk("t2_hold_d0", DataOut[W-1:0], 'h3C);

    // scoreboard set and clear via writeback
    iss(2); clock(); idle(); rd(2, 2);
    #1; check_outputs("t3_busy");
    chk("t3_busy0", Busy[0], 1);
    chk("t3_cnt1", PendCount, 1);
    wr(2, 'h11);
    #1; check_outputs("t3_wb");
    chk("t3_wb_busy0", Busy[0], 0);
    chk("t3_wb_d0", DataOut[W-1:0], 'h11);
    clock(); idle();
    #1; chk("t3_cnt0", PendCount, 0);

    // issue/write collision: issue wins, data still stored
    iss(4); clock(); idle();
    iss(4); wr(4, 'h55); clock(); idle(); rd(4, 4);
    #1; check_outputs("t4_coll");
    chk("t4_busy", Busy[1], 1);
    chk("t4_data", DataOut[2*W-1:W], 'h55);
    chk("t4_cnt", PendCount, 1);

    // fill every register, re-issue, then retire one
    for (int i = 0; i < DEPTH; i++) begin
      iss(i); clock();
    end
    idle();
    #1; check_outputs("t5_full");
    chk("t5_full_cnt", PendCount, DEPTH - ZR);
    iss(0); clock(); idle();
    #1; chk("t5_reiss_cnt", PendCount, DEPTH - ZR);
    wr(7, 'h77); clock(); idle();
    #1; chk("t5_wr7_cnt", PendCount, DEPTH - ZR - 1);

    // register 0 behaviour
    Reset_n = 1'b0; model_clear(); #1; Reset_n = 1'b1;
    clock();
    wr(0, 'hFF); clock(); idle();
    iss(0); clock(); idle(); rd(0, 0);
    #1; check_outputs("t6_r0");
    chk("t6_r0_data", DataOut[W-1:0], ZR ? 0 : 'hFF);
    chk("t6_r0_busy", Busy[0], ZR ? 0 : 1);
    chk("t6_cnt", PendCount, ZR ? 0 : 1);

    // random traffic with occasional asynchronous reset
    for (int n = 0; n < 400; n++) begin
      WriteEn   = ($urandom_range(0, 99) < 45);
      IssueEn   = ($urandom_range(0, 99) < 50);
      Waddr     = D'($urandom);
      IssueAddr = D'($urandom);
      DataIn    = W'($urandom);
      rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      #1; check_outputs("rand");
      if ($urandom_range(0, 99) == 0) begin
        #2; Reset_n = 1'b0; model_clear();
        #1; check_outputs("rand_rst");
        Reset_n = 1'b1;
      end
      clock();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
